// File: rtl/sobel_pix_src.sv
`default_nettype none
// ============================================================================
// Module   : sobel_pix_src
// Brief    : Raster pixel source. Reads RGB565 pixels from a 1-cycle-latency
//            FIFO and emits one frame as a valid/ready stream with sof/eol/eof.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_pix_src #(
    parameter int H_PIX    = 640,
    parameter int V_PIX    = 480,
    parameter int LINE_GAP = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        frame_start,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [15:0] fifo_rd_data,
    input  logic        pix_ready,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic        busy
);

    localparam int c_H_BITS = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int c_V_BITS = (V_PIX > 1) ? $clog2(V_PIX) : 1;
    localparam int c_G_BITS = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
    localparam logic [c_H_BITS-1:0] c_H_LAST = c_H_BITS'(H_PIX - 1);
    localparam logic [c_V_BITS-1:0] c_V_LAST = c_V_BITS'(V_PIX - 1);
    localparam logic [c_G_BITS-1:0] c_G_LAST = c_G_BITS'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_H_BITS-1:0]   r_rd_h;
    logic [c_V_BITS-1:0]   r_rd_v;
    logic [c_H_BITS-1:0]   r_out_h;
    logic [c_V_BITS-1:0]   r_out_v;
    logic [c_G_BITS-1:0]   r_gap_cnt;
    logic                  r_busy;
    logic                  r_inflight;
    logic [15:0]           r_skid [2];
    logic                  r_skid_wr;
    logic                  r_skid_rd;
    logic [1:0]            r_occ;
    logic                  r_out_valid;
    logic [15:0]           r_out_data;

    logic w_rd_en;
    logic w_accept;
    logic w_out_free;
    logic w_skid_pop;
    logic w_bypass;
    logic w_skid_push;
    logic w_sof;
    logic w_eol;
    logic w_eof;

    assign w_rd_en     = (r_state == S_ACTIVE) && !fifo_empty &&
                         ((r_occ + {1'b0, r_inflight}) < 2'd2);
    assign w_accept    = r_out_valid && pix_ready;
    assign w_out_free  = !r_out_valid || pix_ready;
    assign w_skid_pop  = w_out_free && (r_occ != 2'd0);
    // Returning data goes straight to the output stage only when nothing older is queued.
    assign w_bypass    = w_out_free && (r_occ == 2'd0) && r_inflight;
    assign w_skid_push = r_inflight && !w_bypass;

    assign w_sof = (r_out_h == '0) && (r_out_v == '0);
    assign w_eol = (r_out_h == c_H_LAST);
    assign w_eof = w_eol && (r_out_v == c_V_LAST);

    assign fifo_rd_en = w_rd_en;
    assign pix_valid  = r_out_valid;
    assign pix_data   = r_out_data;
    assign pix_sof    = r_out_valid && w_sof;
    assign pix_eol    = r_out_valid && w_eol;
    assign pix_eof    = r_out_valid && w_eof;
    assign busy       = r_busy;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_inflight  <= 1'b0;
            r_skid[0]   <= '0;
            r_skid[1]   <= '0;
            r_skid_wr   <= 1'b0;
            r_skid_rd   <= 1'b0;
            r_occ       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_skid_push) begin
                r_skid[r_skid_wr] <= fifo_rd_data;
                r_skid_wr         <= ~r_skid_wr;
            end
            if (w_skid_pop) begin
                r_skid_rd <= ~r_skid_rd;
            end
            r_occ <= r_occ + {1'b0, w_skid_push} - {1'b0, w_skid_pop};
            if (w_out_free) begin
                r_out_valid <= w_skid_pop || w_bypass;
                if (w_skid_pop) begin
                    r_out_data <= r_skid[r_skid_rd];
                end else if (w_bypass) begin
                    r_out_data <= fifo_rd_data;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            r_rd_h    <= '0;
            r_rd_v    <= '0;
            r_out_h   <= '0;
            r_out_v   <= '0;
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_eol) begin
                    r_out_h <= '0;
                    r_out_v <= w_eof ? '0 : r_out_v + 1'b1;
                end else begin
                    r_out_h <= r_out_h + 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_state   <= S_ACTIVE;
                        r_busy    <= 1'b1;
                        r_rd_h    <= '0;
                        r_rd_v    <= '0;
                        r_out_h   <= '0;
                        r_out_v   <= '0;
                        r_gap_cnt <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (w_rd_en) begin
                        if (r_rd_h == c_H_LAST) begin
                            r_rd_h <= '0;
                            if (r_rd_v == c_V_LAST) begin
                                r_rd_v  <= '0;
                                r_state <= S_DRAIN;
                            end else begin
                                r_rd_v <= r_rd_v + 1'b1;
                                if (LINE_GAP > 0) begin
                                    r_gap_cnt <= '0;
                                    r_state   <= S_GAP;
                                end
                            end
                        end else begin
                            r_rd_h <= r_rd_h + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == c_G_LAST) begin
                        r_state <= S_ACTIVE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_accept && w_eof) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_pix_src.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_pix_src
// Brief    : Self-checking bench for sobel_pix_src (4x3 frame, gaps 2 and 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_pix_src;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int G    = 2;
    localparam int NPIX = H * V;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        frame_start, fifo_empty, fifo_rd_en, pix_ready;
    logic        pix_valid, pix_sof, pix_eol, pix_eof, busy;
    logic [15:0] fifo_rd_data = '0;
    logic [15:0] pix_data;
    logic [15:0] fmem [0:127];
    int          fhead = 0;
    int          ftail = 0;
    logic        force_empty;

    logic        fs_b, fe_b, rd_b, rdy_b, vld_b, sof_b, eol_b, eof_b, busy_b;
    logic [15:0] rdata_b = '0;
    logic [15:0] data_b;
    logic [15:0] fmem_b [0:31];
    int          fhead_b = 0;
    int          ftail_b = 0;

    assign fifo_empty = (fhead >= ftail) || force_empty;
    assign fe_b       = (fhead_b >= ftail_b);

    // FIFO models: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fmem[fhead];
            fhead        <= fhead + 1;
        end
        if (rd_b) begin
            rdata_b <= fmem_b[fhead_b];
            fhead_b <= fhead_b + 1;
        end
    end

    sobel_pix_src #(.H_PIX(H), .V_PIX(V), .LINE_GAP(G)) u_dut (
        .sys_clk(clk), .sys_rst(rst), .frame_start(frame_start),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy)
    );

    sobel_pix_src #(.H_PIX(H), .V_PIX(V), .LINE_GAP(0)) u_dut_g0 (
        .sys_clk(clk), .sys_rst(rst), .frame_start(fs_b),
        .fifo_empty(fe_b), .fifo_rd_en(rd_b), .fifo_rd_data(rdata_b),
        .pix_ready(rdy_b), .pix_valid(vld_b), .pix_data(data_b),
        .pix_sof(sof_b), .pix_eol(eol_b), .pix_eof(eof_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model for u_dut: frame k-th pixel is the FIFO word at the head
    // when the frame was accepted, plus k; markers follow from raster position.
    int          base = 0, k = 0, outstanding = 0;
    int          rd_line = 0, rd_lines = 0, gap_left = 0, frame_reads = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            k = 0; outstanding = 0; prev_stall = 1'b0;
            rd_line = 0; rd_lines = 0; gap_left = 0; frame_reads = 0;
        end else begin
            if (frame_start && !busy) begin
                base = fhead; k = 0; rd_line = 0; rd_lines = 0; gap_left = 0; frame_reads = 0;
            end
            if (prev_stall) check("hold", {15'd0, pix_valid, pix_data}, {15'd0, 1'b1, prev_data});
            if (fifo_rd_en) begin
                check("rd_when_empty", fifo_empty, 0);
                check("rd_budget", outstanding <= 2, 1);
                check("rd_in_gap", gap_left > 0, 0);
            end
            if (gap_left > 0) gap_left--;
            if (fifo_rd_en) begin
                frame_reads++;
                outstanding++;
                rd_line++;
                if (rd_line == H) begin
                    rd_line = 0;
                    rd_lines++;
                    if (rd_lines < V) gap_left = G;
                end
            end
            if (pix_valid) begin
                check("data", pix_data, (base + k < 128) ? fmem[base + k] : 16'hxxxx);
                check("sof", pix_sof, k == 0);
                check("eol", pix_eol, (k % H) == H - 1);
                check("eof", pix_eof, k == NPIX - 1);
                if (pix_ready) begin
                    outstanding--;
                    if (k == NPIX - 1) check("frame_reads", frame_reads, NPIX);
                    k++;
                end
            end
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
        end
    end

    logic [48:1] m_valid, m_busy, m_sof, m_eol, m_eof, m_rd;
    logic [15:0] m_data [1:48];

    // mode: 0 ready=1, 1 ready 1,0,0,1, 2 FIFO empty cycles 8..12,
    //       3 extra frame_start at 6 and 19, 4 ready=0 with reset at 8
    task automatic run_a(input int mode, input int n_cyc);
        @(posedge clk); #1;
        frame_start = 1'b1;
        pix_ready   = 1'b1;
        for (int j = 1; j <= n_cyc; j++) begin
            @(posedge clk); #1;
            frame_start = (mode == 3) && (j == 6 || j == 19);
            rst         = (mode == 4) && (j == 8);
            force_empty = (mode == 2) && (j >= 8) && (j <= 12);
            case (mode)
                1:       pix_ready = ((j - 1) % 4 == 0) || ((j - 1) % 4 == 3);
                4:       pix_ready = 1'b0;
                default: pix_ready = 1'b1;
            endcase
            @(negedge clk);
            m_valid[j] = pix_valid; m_busy[j] = busy; m_sof[j] = pix_sof;
            m_eol[j] = pix_eol; m_eof[j] = pix_eof; m_rd[j] = fifo_rd_en;
            m_data[j] = pix_data;
        end
        @(posedge clk); #1;
        frame_start = 1'b0; rst = 1'b0; force_empty = 1'b0; pix_ready = 1'b1;
    endtask

    task automatic run_b(input int n_cyc);
        int kb;
        kb = 0;
        @(posedge clk); #1;
        fs_b = 1'b1;
        for (int j = 1; j <= n_cyc; j++) begin
            @(posedge clk); #1;
            fs_b = 1'b0;
            @(negedge clk);
            m_valid[j] = vld_b; m_busy[j] = busy_b; m_rd[j] = rd_b;
            if (vld_b) begin
                check("b_data", data_b, 16'(kb + 1));
                check("b_sof", sof_b, kb == 0);
                check("b_eol", eol_b, (kb % H) == H - 1);
                check("b_eof", eof_b, kb == NPIX - 1);
                kb++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; pix_ready = 1'b1; force_empty = 1'b0;
        fs_b = 1'b0; rdy_b = 1'b1;
        for (int i = 0; i < 128; i++) fmem[i] = 16'(i + 1);
        for (int i = 0; i < 32; i++) fmem_b[i] = 16'(i + 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a", {fifo_rd_en, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy}, 0);
        check("reset_b", {rd_b, vld_b, data_b, sof_b, eol_b, eof_b, busy_b}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic frame, no backpressure
        ftail = 12;
        run_a(0, 24);
        check("t1_valid_mask", m_valid[24:1], 24'h03CF3C);
        check("t1_busy_mask",  m_busy[24:1],  24'h03FFFF);
        check("t1_rd_mask",    m_rd[24:1],    24'h00F3CF);
        check("t1_sof_mask",   m_sof[24:1],   24'h000004);
        check("t1_eol_mask",   m_eol[24:1],   24'h020820);
        check("t1_eof_mask",   m_eof[24:1],   24'h020000);
        check("t1_first_data", m_data[3], 16'h0001);
        check("t1_last_data",  m_data[18], 16'h000C);
        repeat (2) @(posedge clk);

        // Backpressure 1,0,0,1
        ftail = 24;
        run_a(1, 60);
        check("t2_done", busy, 0);
        repeat (2) @(posedge clk);

        // FIFO underflow mid-line 1
        ftail = 36;
        run_a(2, 30);
        check("t3_bubble", m_valid[15:9], 7'b1000001);
        check("t3_busy_fall", m_busy[24:23], 2'b01);
        check("t3_eol_count", $countones(m_eol[30:1]), 3);
        repeat (2) @(posedge clk);

        // LINE_GAP = 0 instance
        ftail_b = 12;
        run_b(20);
        check("t4_valid_mask", m_valid[20:1], 20'h03FFC);
        check("t4_busy_mask",  m_busy[20:1],  20'h03FFF);
        check("t4_rd_mask",    m_rd[20:1],    20'h00FFF);
        repeat (2) @(posedge clk);

        // Ignored restart, then back-to-back frame
        ftail = 60;
        run_a(3, 40);
        check("t5_reads_frame1", $countones(m_rd[19:1]), 12);
        check("t5_busy_fall", m_busy[19:18], 2'b01);
        check("t5_f2_sof", {m_valid[22], m_sof[22]}, 2'b11);
        check("t5_f2_data", m_data[22], 16'h0031);
        check("t5_done", busy, 0);
        repeat (2) @(posedge clk);

        // Reset mid-frame with the skid buffer full
        ftail = 72;
        run_a(4, 14);
        check("t6_rd_before", m_rd[8:1], 8'b00000111);
        check("t6_outs_zero", {m_valid[9], m_busy[9], m_sof[9], m_eol[9], m_eof[9], m_data[9], m_rd[9]}, 0);
        check("t6_no_reads", m_rd[14:9], 0);
        repeat (2) @(posedge clk);

        // Fresh frame continues from the FIFO head
        ftail = fhead + 12;
        run_a(0, 24);
        check("t7_first", {m_valid[3], m_sof[3], m_data[3]}, {1'b1, 1'b1, 16'h0040});
        check("t7_busy_mask", m_busy[24:1], 24'h03FFFF);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
